// File: rtl/if_pkg.sv
// Shared types and constants for the WISC instruction fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Next-PC source selected by the fetch FSM at the end of EXEC.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_ALT  = 2'd2
  } pc_sel_t;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction memory read bus between the fetch stage (master) and imem (slave).
// Handshake: the master holds imem_re=1 with a stable imem_addr until the cycle
// imem_rdy=1; that cycle imem_rd_data is valid and the read completes.
interface if_fetch_if;
  logic        imem_re;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_rd_data;

  modport master (output imem_re, imem_addr, input imem_rdy, imem_rd_data);
  modport slave  (input imem_re, imem_addr, output imem_rdy, imem_rd_data);
endinterface

// File: rtl/fetch_pc_reg.sv
// Architectural PC register with load enable and next-PC mux (PC+1 / alt_pc / hold).
module fetch_pc_reg
  import if_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_en,
  input  pc_sel_t     sel,
  input  logic [15:0] alt_pc,
  output logic [15:0] pc
);

  logic [15:0] next_pc;

  // PC+1 wraps naturally at 16 bits.
  always_comb begin
    next_pc = pc;
    case (sel)
      PC_INC:  next_pc = pc + 16'd1;
      PC_ALT:  next_pc = alt_pc;
      default: next_pc = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VAL;
    end else if (ld_en) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Fetch stage: owns the PC, reads imem, presents one instruction to ID per EXEC
// cycle, and applies ID's redirect/halt at the end of that cycle.
module if_fetch
  import if_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hlt,
  input  logic          alt_pc_ctrl,
  input  logic [15:0]   alt_pc,
  if_fetch_if.master    imem,
  output logic [15:0]   instr,
  output logic [15:0]   pc,
  output logic          instr_vld,
  output logic          halted,
  output logic [15:0]   retire_cnt,
  output state_t        state_dbg
);

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic [15:0] pc_q;
  logic        pc_ld;
  pc_sel_t     pc_sel;
  logic        ir_ld;
  logic        retire_inc;
  logic        re;

  fetch_pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld_en  (pc_ld),
    .sel    (pc_sel),
    .alt_pc (alt_pc),
    .pc     (pc_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    re         = 1'b0;
    instr_vld  = 1'b0;
    ir_ld      = 1'b0;
    pc_ld      = 1'b0;
    pc_sel     = PC_HOLD;
    retire_inc = 1'b0;
    case (state)
      FETCH: begin
        re = 1'b1;
        if (imem.imem_rdy) begin
          ir_ld     = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        instr_vld  = 1'b1;
        retire_inc = 1'b1;
        // HLT wins over a simultaneous redirect; the PC then stays on the HLT.
        if (hlt) begin
          state_nxt = HALT;
        end else if (alt_pc_ctrl) begin
          pc_ld     = 1'b1;
          pc_sel    = PC_ALT;
          state_nxt = FETCH;
        end else begin
          pc_ld     = 1'b1;
          pc_sel    = PC_INC;
          state_nxt = FETCH;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= NOP_INSTR;
    end else if (ir_ld) begin
      ir <= imem.imem_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= 16'h0000;
    end else if (retire_inc && (retire_cnt != 16'hFFFF)) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end

  // Outside EXEC, ID sees a NOP so it produces no side effects.
  assign instr          = instr_vld ? ir : NOP_INSTR;
  assign pc             = pc_q;
  assign imem.imem_re   = re;
  assign imem.imem_addr = pc_q;
  assign halted         = (state == HALT);
  assign state_dbg      = state;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed steps plus random fetch latency and
// redirects, checked against a transaction-level model of PC, retire count, halt.
module tb_if_fetch;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hlt = 1'b0;
  logic        alt_pc_ctrl = 1'b0;
  logic [15:0] alt_pc = 16'h0000;
  logic [15:0] instr, pc, retire_cnt;
  logic        instr_vld, halted;
  state_t      state_dbg;

  if_fetch_if imem();

  int errors = 0;
  int checks = 0;

  // Reference model: architectural PC, executed-instruction count, halt flag.
  logic [15:0] m_pc;
  logic [15:0] m_retire;
  logic        m_halted;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hlt         (hlt),
    .alt_pc_ctrl (alt_pc_ctrl),
    .alt_pc      (alt_pc),
    .imem        (imem),
    .instr       (instr),
    .pc          (pc),
    .instr_vld   (instr_vld),
    .halted      (halted),
    .retire_cnt  (retire_cnt),
    .state_dbg   (state_dbg)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_retire = 16'h0000;
    m_halted = 1'b0;
  endtask

  // Checks for any cycle in which no instruction is presented to ID.
  task automatic check_idle(input string tag, input logic exp_re);
    chk({tag, "_vld"},    16'(instr_vld),    16'h0000);
    chk({tag, "_instr"},  instr,             NOP_INSTR);
    chk({tag, "_pc"},     pc,                m_pc);
    chk({tag, "_re"},     16'(imem.imem_re), 16'(exp_re));
    if (exp_re) chk({tag, "_addr"}, imem.imem_addr, m_pc);
    chk({tag, "_halted"}, 16'(halted),       16'(m_halted));
    chk({tag, "_retire"}, retire_cnt,        m_retire);
  endtask

  // Fetch with wait_n not-ready cycles; ID-side inputs carry noise that must be ignored.
  task automatic do_fetch(input int wait_n, input logic [15:0] data);
    for (int i = 0; i < wait_n; i++) begin
      imem.imem_rdy     = 1'b0;
      imem.imem_rd_data = 16'($urandom);
      hlt               = 1'($urandom);
      alt_pc_ctrl       = 1'($urandom);
      alt_pc            = 16'($urandom);
      #1 check_idle("fetch_wait", 1'b1);
      step();
    end
    imem.imem_rdy     = 1'b1;
    imem.imem_rd_data = data;
    hlt               = 1'($urandom);
    alt_pc_ctrl       = 1'($urandom);
    alt_pc            = 16'($urandom);
    #1 check_idle("fetch_rdy", 1'b1);
    step();
  endtask

  task automatic do_exec(input logic h, input logic a, input logic [15:0] t,
                         input logic [15:0] data);
    imem.imem_rdy     = 1'($urandom);
    imem.imem_rd_data = 16'($urandom);
    hlt               = h;
    alt_pc_ctrl       = a;
    alt_pc            = t;
    #1;
    chk("exec_vld",    16'(instr_vld),    16'h0001);
    chk("exec_instr",  instr,             data);
    chk("exec_pc",     pc,                m_pc);
    chk("exec_re",     16'(imem.imem_re), 16'h0000);
    chk("exec_halted", 16'(halted),       16'h0000);
    step();
    m_retire = (m_retire == 16'hFFFF) ? m_retire : m_retire + 16'd1;
    if (h)      m_halted = 1'b1;
    else if (a) m_pc = t;
    else        m_pc = m_pc + 16'd1;
    hlt         = 1'b0;
    alt_pc_ctrl = 1'b0;
  endtask

  task automatic run_instr(input int wait_n, input logic h, input logic a,
                           input logic [15:0] t);
    logic [15:0] d;
    d = 16'($urandom);
    do_fetch(wait_n, d);
    do_exec(h, a, t, d);
  endtask

  // Async reset with a late imem_rdy and stale data presented while reset is held.
  task automatic reset_pulse(input string tag);
    rst_n             = 1'b0;
    imem.imem_rdy     = 1'b1;
    imem.imem_rd_data = 16'hBEEF;
    #1 model_reset();
    chk({tag, "_vld"},    16'(instr_vld), 16'h0000);
    chk({tag, "_instr"},  instr,          NOP_INSTR);
    chk({tag, "_pc"},     pc,             RESET_PC);
    chk({tag, "_halted"}, 16'(halted),    16'h0000);
    chk({tag, "_retire"}, retire_cnt,     16'h0000);
    step();
    chk({tag, "_held_vld"}, 16'(instr_vld), 16'h0000);
    chk({tag, "_held_pc"},  pc,             RESET_PC);
    rst_n         = 1'b1;
    imem.imem_rdy = 1'b0;
    #1 check_idle({tag, "_release"}, 1'b1);
    step();
  endtask

  initial begin
    imem.imem_rdy     = 1'b0;
    imem.imem_rd_data = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_vld",    16'(instr_vld), 16'h0000);
    chk("reset_instr",  instr,          NOP_INSTR);
    chk("reset_halted", 16'(halted),    16'h0000);
    chk("reset_retire", retire_cnt,     16'h0000);
    rst_n = 1'b1;
    #1 check_idle("after_reset", 1'b1);

    // Zero-wait memory: addresses 0..3, two cycles per instruction.
    for (int k = 0; k < 4; k++) run_instr(0, 1'b0, 1'b0, 16'h0000);
    chk("retire_after_4", retire_cnt, 16'd4);

    // PC 4 then a 3-cycle wait at PC 5.
    run_instr(0, 1'b0, 1'b0, 16'h0000);
    run_instr(3, 1'b0, 1'b1, 16'h0010);

    // Redirect and sequential step at 0x10.
    run_instr(0, 1'b0, 1'b1, 16'h0040);
    run_instr(1, 1'b0, 1'b1, 16'h0010);
    run_instr(0, 1'b0, 1'b0, 16'h0000);
    chk("seq_after_0x10", imem.imem_addr, 16'h0011);

    // Wrap from 0xFFFF.
    run_instr(0, 1'b0, 1'b1, 16'hFFFF);
    run_instr(2, 1'b0, 1'b0, 16'h0000);
    chk("wrap_addr", imem.imem_addr, 16'h0000);

    // Random latency and redirects.
    for (int k = 0; k < 40; k++) begin
      run_instr(int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    // Reset while in EXEC, then reset while waiting in FETCH.
    do_fetch(1, 16'h5A5A);
    reset_pulse("rst_exec");
    imem.imem_rdy = 1'b0;
    #1 check_idle("pre_rst_fetch", 1'b1);
    step();
    reset_pulse("rst_fetch");
    run_instr(0, 1'b0, 1'b0, 16'h0000);
    run_instr(1, 1'b0, 1'b1, 16'h0020);

    // HLT together with a redirect at 0x20.
    run_instr(0, 1'b1, 1'b1, 16'h0040);
    for (int k = 0; k < 6; k++) begin
      imem.imem_rdy     = 1'b1;
      imem.imem_rd_data = 16'($urandom);
      hlt               = 1'($urandom);
      alt_pc_ctrl       = 1'($urandom);
      alt_pc            = 16'($urandom);
      #1 check_idle("halt", 1'b0);
      step();
    end
    chk("halt_pc", pc, 16'h0020);

    // Reset leaves HALT and fetching resumes at RESET_PC.
    reset_pulse("rst_halt");
    run_instr(0, 1'b0, 1'b0, 16'h0000);
    #1 check_idle("final", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage for the WISC single-cycle processor, directly upstream of the ID stage. Owns the architectural PC, issues reads to a variable-latency instruction memory, and presents one instruction plus its PC to ID for exactly one execute cycle. At the end of that cycle it consumes ID's redirect (`alt_pc_ctrl`/`alt_pc`) and halt indication to select the next PC.

## Interface

- `RESET_PC`, 16'h0000: PC loaded on reset.
- `NOP_INSTR`, 16'h0000: instruction driven to ID when no instruction is being executed (ADD R0,R0,R0; R0 write discarded).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hlt`  in  1  from ID: current instruction is HLT.
- `alt_pc_ctrl`  in  1  from ID: take `alt_pc` as next PC.
- `alt_pc`  in  16  from ID: branch/jump target.
- `imem_rdy`  in  1  instruction memory: `imem_rd_data` valid this cycle.
- `imem_rd_data`  in  16  instruction memory read data.
- `imem_re`  out  1  instruction memory read request.
- `imem_addr`  out  16  instruction memory read address.
- `instr`  out  16  instruction to ID.
- `pc`  out  16  PC of `instr`, to ID.
- `instr_vld`  out  1  `instr`/`pc` are a real instruction this cycle.
- `halted`  out  1  processor has executed HLT.
- `retire_cnt`  out  16  count of executed instructions.

## Operation

- States: FETCH, EXEC, HALT. Reset state FETCH.
- FETCH: `imem_re`=1, `imem_addr`=PC register. When `imem_rdy`=1: capture `imem_rd_data` into instruction register, go EXEC. Otherwise stay, address held.
- EXEC: `instr_vld`=1, `instr`=instruction register, `pc`=PC register, `imem_re`=0. At clock edge:
  - `hlt`=1: PC unchanged, go HALT (`hlt` has priority over `alt_pc_ctrl`).
  - else `alt_pc_ctrl`=1: PC <= `alt_pc`, go FETCH.
  - else PC <= PC+1 (16-bit, 16'hFFFF wraps to 16'h0000), go FETCH.
  - `retire_cnt` increments (saturates at 16'hFFFF), including for HLT.
- HALT: terminal until reset. `halted`=1, `imem_re`=0, `instr_vld`=0.
- Whenever `instr_vld`=0, `instr` = `NOP_INSTR` so ID produces no register writes, memory accesses, redirects, or halts; `pc` still shows PC register.
- `hlt`, `alt_pc_ctrl`, `alt_pc` ignored outside EXEC. `imem_rdy` ignored outside FETCH.

## Timing

- Reset values (asynchronous): state FETCH, PC=`RESET_PC`, instruction register=`NOP_INSTR`, `retire_cnt`=0, `halted`=0, `instr_vld`=0, `imem_re`=1 and `imem_addr`=`RESET_PC` once `rst_n` deasserted (combinational from state).
- Zero-wait memory (`imem_rdy` same cycle as `imem_re`): 2 cycles per instruction (FETCH, EXEC).
- N wait cycles: N+2 cycles per instruction.
- `imem_addr` stable while `imem_re`=1 until the `imem_rdy` cycle.
- ID outputs sampled at end of the single EXEC cycle; ID must settle combinationally within it.
- Reset asserted mid-FETCH or mid-EXEC: immediate return to reset values; pending memory read abandoned; any late `imem_rdy` ignored unless in FETCH.
- `halted` asserts the cycle after HLT's EXEC cycle and stays until reset.

## Structure

- Shared package `if_pkg`: state enum (FETCH, EXEC, HALT), default `NOP_INSTR` and `RESET_PC` constants, next-PC select encoding.
- One sub-module: `fetch_pc_reg` — PC register with async reset, load enable, and next-PC mux (PC+1 / `alt_pc` / hold).
- FSM, instruction register, and retire counter in `if_fetch` top.

## Test plan

- Reset, `imem_rdy` tied 1, memory returns ADDs at 0..3 -> `imem_addr` 0,1,2,3 on alternate cycles; `instr_vld` toggles 0,1; `retire_cnt`=4 after 8 cycles.
- `imem_rdy` delayed 3 cycles -> `imem_addr` held at 16'h0005 for 4 cycles, `instr_vld` low, `instr`=`NOP_INSTR`; EXEC follows rdy by one cycle.
- EXEC at PC 16'h0010 with `alt_pc_ctrl`=1, `alt_pc`=16'h0040 -> next `imem_addr`=16'h0040; with `alt_pc_ctrl`=0 -> 16'h0011.
- PC=16'hFFFF, no redirect -> next `imem_addr`=16'h0000.
- `hlt`=1 together with `alt_pc_ctrl`=1 at PC 16'h0020 -> HALT, `halted`=1 next cycle, PC stays 16'h0020, `imem_re`=0 forever, `retire_cnt` incremented once.
- `rst_n` pulsed low mid-FETCH with `imem_rdy` arriving during reset -> all outputs at reset values, fetch restarts at `RESET_PC`, captured data discarded.
